capa_fisica: RTL and testbench

CAPA_FISICA -- requirements
Module: capa_fisica

---
 rtl/capa_fisica.sv | 133 +++++++++++++
 tb/tb_capa_fisica.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/capa_fisica.sv
// capa_fisica: command-line PHY; serialises a 48-bit command frame and captures a 15-bit response or times out.
// Define CMD_CRC7_EN to generate the CRC7 field; without it the CRC bits go out as zeros.
module capa_fisica (
  input  logic        sd_clock,
  input  logic        reset,
  input  logic        strobe_in,
  input  logic        ack_in,
  input  logic        idle_in,
  input  logic [39:0] cmd_to_send,
  input  logic        no_response,
  input  logic        cmd_pin_in,
  output logic        ack_out,
  output logic        strobe_out,
  output logic [14:0] response,
  output logic        command_timeout,
  output logic        cmd_pin_out
);

  typedef enum logic [2:0] {IDLE, SEND, WAIT_RESP, RECEIVE, DONE} state_t;

  state_t      state;
  logic [46:0] frame_sr;
  logic [5:0]  cnt;
  logic        nr_q;
  logic [6:0]  crc_field;
  logic [47:0] frame_next;

`ifdef CMD_CRC7_EN
  function automatic logic [6:0] crc7(input logic [39:0] d);
    logic [6:0] c;
    logic       fb;
    c = '0;
    for (int i = 39; i >= 0; i--) begin
      fb = d[i] ^ c[6];
      c  = {c[5:0], 1'b0};
      if (fb) c = c ^ 7'h09;
    end
    return c;
  endfunction

  assign crc_field = crc7(cmd_to_send);
`else
  assign crc_field = 7'd0;
`endif

  assign frame_next = {cmd_to_send, crc_field, 1'b1};

  always_ff @(posedge sd_clock) begin
    if (!reset) begin
      state           <= IDLE;
      frame_sr        <= '0;
      cnt             <= '0;
      nr_q            <= 1'b0;
      ack_out         <= 1'b0;
      strobe_out      <= 1'b0;
      response        <= '0;
      command_timeout <= 1'b0;
      cmd_pin_out     <= 1'b1;
    end else if (idle_in) begin
      state           <= IDLE;
      cnt             <= '0;
      ack_out         <= 1'b0;
      strobe_out      <= 1'b0;
      command_timeout <= 1'b0;
      cmd_pin_out     <= 1'b1;
    end else begin
      ack_out <= 1'b0;
      case (state)
        IDLE: begin
          if (strobe_in) begin
            // First frame bit is launched together with the accept so SEND lasts exactly 48 cycles.
            frame_sr    <= frame_next[46:0];
            cmd_pin_out <= frame_next[47];
            nr_q        <= no_response;
            ack_out     <= 1'b1;
            cnt         <= '0;
            state       <= SEND;
          end
        end
        SEND: begin
          if (cnt == 6'd47) begin
            cnt         <= '0;
            cmd_pin_out <= 1'b1;
            if (nr_q) begin
              response   <= '0;
              strobe_out <= 1'b1;
              state      <= DONE;
            end else begin
              state <= WAIT_RESP;
            end
          end else begin
            cnt         <= cnt + 6'd1;
            cmd_pin_out <= frame_sr[46];
            frame_sr    <= {frame_sr[45:0], 1'b1};
          end
        end
        WAIT_RESP: begin
          if (!cmd_pin_in) begin
            cnt   <= '0;
            state <= RECEIVE;
          end else if (cnt == 6'd63) begin
            cnt             <= '0;
            response        <= '0;
            command_timeout <= 1'b1;
            strobe_out      <= 1'b1;
            state           <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        RECEIVE: begin
          response <= {response[13:0], cmd_pin_in};
          if (cnt == 6'd14) begin
            cnt        <= '0;
            strobe_out <= 1'b1;
            state      <= DONE;
          end else begin
            cnt <= cnt + 6'd1;
          end
        end
        DONE: begin
          if (ack_in) begin
            strobe_out      <= 1'b0;
            command_timeout <= 1'b0;
            state           <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_capa_fisica.sv
// Bench for capa_fisica: table of known frames, random transactions against a polynomial-division model, abort/reset sequences.
module tb_capa_fisica;

  logic        sd_clock = 1'b0;
  logic        reset;
  logic        strobe_in, ack_in, idle_in, no_response, cmd_pin_in;
  logic [39:0] cmd_to_send;
  logic        ack_out, strobe_out, command_timeout, cmd_pin_out;
  logic [14:0] response;

  int n_cmp = 0;
  int n_err = 0;
  logic [14:0] last_resp = '0;

  capa_fisica dut (
    .sd_clock(sd_clock), .reset(reset), .strobe_in(strobe_in), .ack_in(ack_in),
    .idle_in(idle_in), .cmd_to_send(cmd_to_send), .no_response(no_response),
    .cmd_pin_in(cmd_pin_in), .ack_out(ack_out), .strobe_out(strobe_out),
    .response(response), .command_timeout(command_timeout), .cmd_pin_out(cmd_pin_out)
  );

  always #5 sd_clock = ~sd_clock;

  typedef struct {
    logic [39:0] cmd;
    logic        nr;
    logic        resp_en;
    logic [14:0] rbits;
    int          gap;
    logic [47:0] exp_frame;
    logic [14:0] exp_resp;
    logic        exp_to;
  } vec_t;

  // CRC as remainder of m(x)*x^7 divided by x^7+x^3+1.
  function automatic logic [6:0] ref_crc(input logic [39:0] m);
    logic [46:0] r;
    r = {m, 7'd0};
    for (int i = 46; i >= 7; i--)
      if (r[i]) r = r ^ (47'h89 << (i - 7));
    return r[6:0];
  endfunction

  function automatic logic [47:0] ref_frame(input logic [39:0] m);
`ifdef CMD_CRC7_EN
    return {m, ref_crc(m), 1'b1};
`else
    return {m, 7'd0, 1'b1};
`endif
  endfunction

  task automatic check(input string nm, input logic [47:0] act, input logic [47:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic start_txn(input logic [39:0] cmd, input logic nr, input string nm);
    @(negedge sd_clock);
    cmd_to_send = cmd; no_response = nr; strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    cmd_to_send = ~cmd;
    check({nm, " ack_out"}, {47'd0, ack_out}, 48'd1);
  endtask

  task automatic run_txn(input vec_t v, input string nm);
    logic [47:0] got;
    start_txn(v.cmd, v.nr, nm);
    for (int i = 0; i < 48; i++) begin
      got[47-i] = cmd_pin_out;
      if (i == 1) check({nm, " ack one cycle"}, {47'd0, ack_out}, 48'd0);
      @(negedge sd_clock);
    end
    check({nm, " frame"}, got, v.exp_frame);
    check({nm, " pin idle after frame"}, {47'd0, cmd_pin_out}, 48'd1);
    if (!v.nr && v.resp_en) begin
      repeat (v.gap) @(negedge sd_clock);
      cmd_pin_in = 1'b0;
      @(negedge sd_clock);
      for (int i = 14; i >= 0; i--) begin
        cmd_pin_in = v.rbits[i];
        @(negedge sd_clock);
      end
      cmd_pin_in = 1'b1;
    end else if (!v.nr) begin
      repeat (63) @(negedge sd_clock);
      check({nm, " no early timeout"}, {47'd0, strobe_out}, 48'd0);
      @(negedge sd_clock);
    end
    check({nm, " strobe_out"}, {47'd0, strobe_out}, 48'd1);
    check({nm, " timeout"}, {47'd0, command_timeout}, {47'd0, v.exp_to});
    check({nm, " response"}, {33'd0, response}, {33'd0, v.exp_resp});
    repeat (3) @(negedge sd_clock);
    check({nm, " strobe held"}, {47'd0, strobe_out}, 48'd1);
    ack_in = 1'b1;
    @(negedge sd_clock);
    ack_in = 1'b0;
    check({nm, " strobe cleared"}, {47'd0, strobe_out}, 48'd0);
    check({nm, " timeout cleared"}, {47'd0, command_timeout}, 48'd0);
    check({nm, " response kept"}, {33'd0, response}, {33'd0, v.exp_resp});
    last_resp = v.exp_resp;
  endtask

  vec_t tbl[3];

  initial begin
    vec_t v;
`ifdef CMD_CRC7_EN
    tbl[0] = '{40'h40_0000_0000, 1'b1, 1'b0, 15'h0, 0, 48'h40_0000_0000_95, 15'h0, 1'b0};
    tbl[1] = '{40'h48_0000_01AA, 1'b0, 1'b1, 15'h5A5A, 3, 48'h48_0000_01AA_87, 15'h5A5A, 1'b0};
`else
    tbl[0] = '{40'h40_0000_0000, 1'b1, 1'b0, 15'h0, 0, 48'h40_0000_0000_01, 15'h0, 1'b0};
    tbl[1] = '{40'h48_0000_01AA, 1'b0, 1'b1, 15'h5A5A, 3, 48'h48_0000_01AA_01, 15'h5A5A, 1'b0};
`endif
    tbl[2] = '{40'h77_1234_5678, 1'b0, 1'b0, 15'h0, 0, ref_frame(40'h77_1234_5678), 15'h0, 1'b1};

    reset = 1'b0; strobe_in = 1'b0; ack_in = 1'b0; idle_in = 1'b0;
    no_response = 1'b0; cmd_pin_in = 1'b1; cmd_to_send = '0;
    repeat (2) @(negedge sd_clock);
    check("reset ack_out", {47'd0, ack_out}, 48'd0);
    check("reset strobe_out", {47'd0, strobe_out}, 48'd0);
    check("reset timeout", {47'd0, command_timeout}, 48'd0);
    check("reset response", {33'd0, response}, 48'd0);
    check("reset pin", {47'd0, cmd_pin_out}, 48'd1);
    reset = 1'b1;

    for (int i = 0; i < 3; i++) run_txn(tbl[i], $sformatf("tbl%0d", i));

    for (int k = 0; k < 12; k++) begin
      v.cmd       = {$urandom, $urandom} & 40'hFF_FFFF_FFFF;
      v.nr        = ($urandom_range(0, 3) == 0);
      v.resp_en   = ($urandom_range(0, 4) != 0);
      v.rbits     = 15'($urandom);
      v.gap       = $urandom_range(0, 40);
      v.exp_frame = ref_frame(v.cmd);
      v.exp_resp  = (!v.nr && v.resp_en) ? v.rbits : 15'd0;
      v.exp_to    = !v.nr && !v.resp_en;
      run_txn(v, $sformatf("rnd%0d", k));
    end

    // Abort in the middle of the frame.
    start_txn(40'h40_0000_0000, 1'b0, "abort");
    repeat (20) @(negedge sd_clock);
    check("abort bit20 driven", {47'd0, cmd_pin_out}, 48'd0);
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    check("abort pin", {47'd0, cmd_pin_out}, 48'd1);
    check("abort strobe", {47'd0, strobe_out}, 48'd0);
    check("abort response kept", {33'd0, response}, {33'd0, last_resp});
    repeat (100) @(negedge sd_clock);
    check("abort no completion", {47'd0, strobe_out}, 48'd0);
    check("abort pin stays idle", {47'd0, cmd_pin_out}, 48'd1);

    // idle_in beats strobe_in in IDLE.
    @(negedge sd_clock);
    strobe_in = 1'b1; idle_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0; idle_in = 1'b0;
    check("idle wins ack", {47'd0, ack_out}, 48'd0);
    repeat (5) @(negedge sd_clock);
    check("idle wins pin", {47'd0, cmd_pin_out}, 48'd1);

    // Busy strobe ignored, then reset mid-RECEIVE.
    start_txn(40'h48_0000_01AA, 1'b0, "rst");
    repeat (48) @(negedge sd_clock);
    strobe_in = 1'b1;
    @(negedge sd_clock);
    strobe_in = 1'b0;
    check("busy strobe ignored", {47'd0, ack_out}, 48'd0);
    cmd_pin_in = 1'b0;
    @(negedge sd_clock);
    for (int i = 14; i >= 8; i--) begin
      cmd_pin_in = ~i[0];
      @(negedge sd_clock);
    end
    reset = 1'b0;
    @(negedge sd_clock);
    reset = 1'b1; cmd_pin_in = 1'b1;
    check("rst ack_out", {47'd0, ack_out}, 48'd0);
    check("rst strobe_out", {47'd0, strobe_out}, 48'd0);
    check("rst timeout", {47'd0, command_timeout}, 48'd0);
    check("rst response", {33'd0, response}, 48'd0);
    check("rst pin", {47'd0, cmd_pin_out}, 48'd1);
    repeat (20) @(negedge sd_clock);
    check("rst no completion", {47'd0, strobe_out}, 48'd0);

    // idle_in in DONE clears a pending timeout.
    start_txn(40'h51_0000_0000, 1'b0, "idle_done");
    repeat (48 + 64) @(negedge sd_clock);
    check("idle_done timeout set", {47'd0, command_timeout}, 48'd1);
    idle_in = 1'b1;
    @(negedge sd_clock);
    idle_in = 1'b0;
    check("idle_done timeout cleared", {47'd0, command_timeout}, 48'd0);
    check("idle_done strobe cleared", {47'd0, strobe_out}, 48'd0);

    run_txn(tbl[1], "recover");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
